// File: rtl/infra_red_pkg.sv
// Shared types and timing windows for the NEC infrared receiver.
package infra_red_pkg;

  localparam int DUR_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MK,
    LEAD_SP,
    BIT_MK,
    BIT_SP,
    REP_MK,
    TRAIL
  } ir_state_e;

  // Acceptance windows in microseconds, both ends inclusive.
  localparam logic [DUR_W-1:0] LEAD_MARK_MIN  = 14'd8000;
  localparam logic [DUR_W-1:0] LEAD_MARK_MAX  = 14'd10000;
  localparam logic [DUR_W-1:0] LEAD_SPACE_MIN = 14'd4000;
  localparam logic [DUR_W-1:0] LEAD_SPACE_MAX = 14'd5000;
  localparam logic [DUR_W-1:0] REP_SPACE_MIN  = 14'd1750;
  localparam logic [DUR_W-1:0] REP_SPACE_MAX  = 14'd2750;
  localparam logic [DUR_W-1:0] BIT_MARK_MIN   = 14'd400;
  localparam logic [DUR_W-1:0] BIT_MARK_MAX   = 14'd750;
  localparam logic [DUR_W-1:0] ZERO_SPACE_MIN = 14'd400;
  localparam logic [DUR_W-1:0] ZERO_SPACE_MAX = 14'd750;
  localparam logic [DUR_W-1:0] ONE_SPACE_MIN  = 14'd1400;
  localparam logic [DUR_W-1:0] ONE_SPACE_MAX  = 14'd1950;

  function automatic logic in_win(input logic [DUR_W-1:0] d,
                                  input logic [DUR_W-1:0] lo,
                                  input logic [DUR_W-1:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Input synchroniser, mark polarity, edge detect and microsecond phase timer.
module ir_pulse_timer
  import infra_red_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ir_i,
  output logic             data_ir_o,
  output logic             mark_o,
  output logic             edge_o,
  output logic [DUR_W-1:0] dur_o
);

  localparam int PRESC = CLK_HZ / 1000000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mark_q;
  logic [PW-1:0]          presc_q, presc_d;
  logic [DUR_W-1:0]       dur_q, dur_d;
  logic                   tick;

  assign data_ir_o = sync_q[SYNC_STAGES-1];
  assign mark_o    = data_ir_o ^ IDLE_LVL;
  assign edge_o    = mark_o ^ mark_q;
  assign tick      = (presc_q == PRESC_LAST);
  assign dur_o     = dur_q;

  // Shift the raw input through the synchroniser; reset parks it at the idle level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{IDLE_LVL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], ir_i};
  end

  // Phase timer: an edge restarts both counters and beats a coincident tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    dur_d   = dur_q;
    if (tick && (dur_q != '1)) dur_d = dur_q + 1'b1;
    if (edge_o) begin
      presc_d = '0;
      dur_d   = '0;
    end
  end

  // Timer and previous-mark registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mark_q  <= 1'b0;
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      mark_q  <= mark_o;
      presc_q <= presc_d;
      dur_q   <= dur_d;
    end
  end

endmodule

// File: rtl/infra_red_nec_rx.sv
// NEC frame and repeat-code decoder: phase FSM, 32-bit shift register, checksum.
module infra_red_nec_rx
  import infra_red_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int TIMEOUT_US  = 12000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ir_i,
  output logic       data_ir_o,
  output logic [7:0] addr_o,
  output logic [7:0] cmd_o,
  output logic       valid_o,
  output logic       repeat_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam logic [DUR_W-1:0] TO = DUR_W'(TIMEOUT_US);

  logic             mark, edg;
  logic [DUR_W-1:0] dur;

  ir_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d, sr_shift;
  logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;
  logic        have_q, have_d;
  logic        valid_q, valid_d, rep_q, rep_d, err_q, err_d;
  logic        is_zero, is_one, tmo;

  ir_pulse_timer #(
    .CLK_HZ     (CLK_HZ),
    .SYNC_STAGES(SYNC_STAGES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ir_i     (ir_i),
    .data_ir_o(data_ir_o),
    .mark_o   (mark),
    .edge_o   (edg),
    .dur_o    (dur)
  );

  assign is_zero  = in_win(dur, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
  assign is_one   = in_win(dur, ONE_SPACE_MIN, ONE_SPACE_MAX);
  assign sr_shift = {is_one, sr_q[31:1]};
  assign tmo      = (dur >= TO);

  // Phase decisions are made on the edge that closes each mark or space.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    have_d  = have_q;
    valid_d = 1'b0;
    rep_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:    if (edg && mark) state_d = LEAD_MK;
      LEAD_MK: begin
        // Short bursts are treated as line noise and dropped without error.
        if (edg) state_d = in_win(dur, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SP : IDLE;
        else if (tmo) state_d = IDLE;
      end
      LEAD_SP: begin
        if (edg) begin
          if (in_win(dur, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            state_d = BIT_MK;
            cnt_d   = '0;
          end else if (in_win(dur, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            state_d = REP_MK;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      BIT_MK: begin
        if (edg) begin
          if (in_win(dur, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SP;
          else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      BIT_SP: begin
        if (edg) begin
          if (is_zero || is_one) begin
            sr_d = sr_shift;
            if (cnt_q != 5'd31) begin
              cnt_d   = cnt_q + 1'b1;
              state_d = BIT_MK;
            end else if ((sr_shift[15:8] == ~sr_shift[7:0]) &&
                         (sr_shift[31:24] == ~sr_shift[23:16])) begin
              addr_d  = sr_shift[7:0];
              cmd_d   = sr_shift[23:16];
              valid_d = 1'b1;
              have_d  = 1'b1;
              state_d = TRAIL;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      REP_MK: begin
        if (edg) begin
          state_d = IDLE;
          if (in_win(dur, BIT_MARK_MIN, BIT_MARK_MAX)) rep_d = have_q;
          else err_d = 1'b1;
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      TRAIL: begin
        // Swallow the stop burst so it cannot look like a new leader.
        if (edg || (dur > TO)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoder state and registered output strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      addr_q  <= '0;
      cmd_q   <= '0;
      have_q  <= 1'b0;
      valid_q <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      have_q  <= have_d;
      valid_q <= valid_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
    end
  end

  assign addr_o   = addr_q;
  assign cmd_o    = cmd_q;
  assign valid_o  = valid_q;
  assign repeat_o = rep_q;
  assign err_o    = err_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_infra_red_nec_rx.sv
// Directed bench for the NEC receiver at a 1 MHz clock (one cycle per microsecond).
`timescale 1ns/1ps
module tb_infra_red_nec_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir  = 1'b1;
  logic       data_ir, valid, rep, err, busy;
  logic [7:0] addr, cmd;

  int checks = 0, failures = 0;
  int n_valid = 0, n_rep = 0, n_err = 0;
  logic [7:0] v_addr = '0, v_cmd = '0;

  always #500 clk = ~clk;

  infra_red_nec_rx #(
    .CLK_HZ     (1000000),
    .SYNC_STAGES(2),
    .ACTIVE_LOW (1),
    .TIMEOUT_US (12000)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ir_i     (ir),
    .data_ir_o(data_ir),
    .addr_o   (addr),
    .cmd_o    (cmd),
    .valid_o  (valid),
    .repeat_o (rep),
    .err_o    (err),
    .busy_o   (busy)
  );

  // Count strobe cycles; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      v_addr  <= addr;
      v_cmd   <= cmd;
    end
    if (rep) n_rep <= n_rep + 1;
    if (err) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int us);
    ir = lvl;
    repeat (us) @(negedge clk);
  endtask

  task automatic mk(input int us); hold(1'b0, us); endtask
  task automatic sp(input int us); hold(1'b1, us); endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    mk(9000);
    sp(4500);
    for (int i = 0; i < n; i++) begin
      mk(560);
      sp(w[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c,
                            input logic [7:0] b3, input int gap);
    send_bits({b3, c, ~a, a}, 32);
    mk(560);
    sp(gap);
  endtask

  task automatic send_rep(input int gap);
    mk(9000);
    sp(2250);
    mk(560);
    sp(gap);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data_ir", 32'(data_ir), 32'h1);
    chk("rst_strobes", 32'({valid, rep, err}), 32'h0);
    rst = 1'b0;
    sp(100);

    // Repeat code with no prior frame: silent.
    send_rep(3000);
    chk("rep_nofrm_rep", 32'(n_rep), 32'd0);
    chk("rep_nofrm_err", 32'(n_err), 32'd0);
    chk("rep_nofrm_busy", 32'(busy), 32'h0);

    // 300 us glitch, then frame 04/08.
    mk(300);
    sp(3000);
    chk("glitch_err", 32'(n_err), 32'd0);
    send_frame(8'h04, 8'h08, 8'hF7, 3000);
    chk("frmA_valid", 32'(n_valid), 32'd1);
    chk("frmA_addr", 32'(addr), 32'h04);
    chk("frmA_cmd", 32'(cmd), 32'h08);
    chk("frmA_vaddr", 32'(v_addr), 32'h04);
    chk("frmA_vcmd", 32'(v_cmd), 32'h08);
    chk("frmA_err", 32'(n_err), 32'd0);
    chk("frmA_rep", 32'(n_rep), 32'd0);
    chk("frmA_busy", 32'(busy), 32'h0);

    // Repeat code after a valid frame.
    send_rep(3000);
    chk("rep_cnt", 32'(n_rep), 32'd1);
    chk("rep_valid", 32'(n_valid), 32'd1);
    chk("rep_addr", 32'(addr), 32'h04);
    chk("rep_cmd", 32'(cmd), 32'h08);
    chk("rep_err", 32'(n_err), 32'd0);

    // Bad command checksum.
    send_frame(8'h04, 8'h08, 8'hF6, 3000);
    chk("bad_err", 32'(n_err), 32'd1);
    chk("bad_valid", 32'(n_valid), 32'd1);
    chk("bad_addr", 32'(addr), 32'h04);
    chk("bad_cmd", 32'(cmd), 32'h08);

    // Stall in a bit space until the timeout fires.
    send_bits(32'hF708FB04, 4);
    mk(560);
    sp(11900);
    chk("tmo_busy_pre", 32'(busy), 32'h1);
    chk("tmo_err_pre", 32'(n_err), 32'd1);
    sp(400);
    chk("tmo_err", 32'(n_err), 32'd2);
    chk("tmo_busy", 32'(busy), 32'h0);
    sp(1000);

    // Reset in the middle of a frame.
    send_bits(32'hC33C5AA5, 16);
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(addr), 32'h0);
    chk("mid_rst_cmd", 32'(cmd), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sp(2000);

    // have_frame cleared by reset: repeat is ignored.
    send_rep(3000);
    chk("rst_rep", 32'(n_rep), 32'd1);
    chk("rst_rep_err", 32'(n_err), 32'd2);

    // Fresh frame A5/3C.
    send_frame(8'hA5, 8'h3C, 8'hC3, 3000);
    chk("frmB_valid", 32'(n_valid), 32'd2);
    chk("frmB_addr", 32'(addr), 32'hA5);
    chk("frmB_cmd", 32'(cmd), 32'h3C);
    chk("frmB_err", 32'(n_err), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
